pn_chip_spreader: RTL and testbench

//  DSSS spreading stage directly downstream of the 7-bit PN chip generator (period 127).

---
 rtl/pn_chip_spreader.sv | 179 +++++++++++++++++
 tb/tb_pn_chip_spreader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_chip_spreader.sv
// pn_chip_spreader: DSSS spreading stage fed by a 7-bit (period 127) PN chip generator.
// Each accepted data bit is XORed with CHIPS_PER_BIT consecutive PN chips. The output chip
// stream is registered and runs at the chip (clk) rate. A free-running chip counter is
// released from reset together with the PN generator, so chip 0 of every bit slot lines up
// with the generator's epoch.
//
// Optional feature: define PN_PREAMBLE_EN to send PREAMBLE_BITS slots of '1' before the
// first data bit that follows an idle period.
//
// Ports
//   clk            chip clock, one PN chip per cycle
//   reset_n        synchronous, active-low reset
//   pn_chip_i      PN chip from the generator (leaves reset on the same edge as this block)
//   in_valid_i     data bit available
//   in_bit_i       data bit
//   in_ready_o     holding register empty; a bit transfers when in_valid_i & in_ready_o
//   chip_out_o     spread chip (0 when chip_valid_o is 0)
//   chip_valid_o   chip_out_o carries a spread bit
//   bit_start_o    pulse on chip 0 of each spread bit
//   underrun_cnt_o saturating count of empty bit slots that follow an active slot
module pn_chip_spreader #(
  parameter int unsigned CHIPS_PER_BIT = 127,
  parameter int unsigned UNDERRUN_W    = 8,
  parameter int unsigned PREAMBLE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pn_chip_i,
  input  logic                  in_valid_i,
  input  logic                  in_bit_i,
  output logic                  in_ready_o,
  output logic                  chip_out_o,
  output logic                  chip_valid_o,
  output logic                  bit_start_o,
  output logic [UNDERRUN_W-1:0] underrun_cnt_o
);

  if (CHIPS_PER_BIT < 2 || CHIPS_PER_BIT > 255) begin : gen_bad_chips_per_bit
    $error("CHIPS_PER_BIT must be in 2..255");
  end
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 15) begin : gen_bad_preamble_bits
    $error("PREAMBLE_BITS must be in 1..15");
  end

  localparam logic [7:0] LastChip = 8'(CHIPS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData
`ifdef PN_PREAMBLE_EN
    , StPreamble
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            chip_cnt_q, chip_cnt_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  hold_bit_q, hold_bit_d;
  logic                  cur_bit_q, cur_bit_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic                  chip_out_q, chip_out_d;
  logic                  chip_valid_q, chip_valid_d;
  logic                  bit_start_q, bit_start_d;
`ifdef PN_PREAMBLE_EN
  localparam logic [3:0] LastPreamble = 4'(PREAMBLE_BITS - 1);
  logic [3:0]            preamble_cnt_q, preamble_cnt_d;
`endif

  logic boundary;
  logic transfer;
  logic active;

  // Ready is forced low while reset is asserted so nothing can be accepted then.
  assign in_ready_o = reset_n & ~hold_vld_q;
  assign transfer   = in_valid_i & in_ready_o;
  assign boundary   = (chip_cnt_q == LastChip);
  assign active     = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    hold_vld_d   = hold_vld_q;
    hold_bit_d   = hold_bit_q;
    cur_bit_d    = cur_bit_q;
    underrun_d   = underrun_q;
    chip_cnt_d   = boundary ? 8'd0 : chip_cnt_q + 8'd1;
`ifdef PN_PREAMBLE_EN
    preamble_cnt_d = preamble_cnt_q;
`endif

    // A transfer can only happen while the register is empty, so it never collides with a
    // load below; one taken in a boundary cycle simply waits for the next boundary.
    if (transfer) begin
      hold_vld_d = 1'b1;
      hold_bit_d = in_bit_i;
    end

    if (boundary) begin
      unique case (state_q)
        StIdle: begin
          if (hold_vld_q) begin
`ifdef PN_PREAMBLE_EN
            // Held bit stays parked (in_ready low) until the preamble has gone out.
            state_d        = StPreamble;
            cur_bit_d      = 1'b1;
            preamble_cnt_d = 4'd0;
`else
            state_d    = StData;
            cur_bit_d  = hold_bit_q;
            hold_vld_d = 1'b0;
`endif
          end
        end
        StData: begin
          if (hold_vld_q) begin
            cur_bit_d  = hold_bit_q;
            hold_vld_d = 1'b0;
          end else begin
            state_d = StIdle;
            if (underrun_q != {UNDERRUN_W{1'b1}}) begin
              underrun_d = underrun_q + 1'b1;
            end
          end
        end
`ifdef PN_PREAMBLE_EN
        StPreamble: begin
          if (preamble_cnt_q == LastPreamble) begin
            state_d    = StData;
            cur_bit_d  = hold_bit_q;
            hold_vld_d = 1'b0;
          end else begin
            preamble_cnt_d = preamble_cnt_q + 4'd1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    chip_out_d   = active & (cur_bit_q ^ pn_chip_i);
    chip_valid_d = active;
    bit_start_d  = active & (chip_cnt_q == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      chip_cnt_q   <= 8'd0;
      hold_vld_q   <= 1'b0;
      hold_bit_q   <= 1'b0;
      cur_bit_q    <= 1'b0;
      underrun_q   <= '0;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
      bit_start_q  <= 1'b0;
`ifdef PN_PREAMBLE_EN
      preamble_cnt_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      chip_cnt_q   <= chip_cnt_d;
      hold_vld_q   <= hold_vld_d;
      hold_bit_q   <= hold_bit_d;
      cur_bit_q    <= cur_bit_d;
      underrun_q   <= underrun_d;
      chip_out_q   <= chip_out_d;
      chip_valid_q <= chip_valid_d;
      bit_start_q  <= bit_start_d;
`ifdef PN_PREAMBLE_EN
      preamble_cnt_q <= preamble_cnt_d;
`endif
    end
  end

  assign chip_out_o     = chip_out_q;
  assign chip_valid_o   = chip_valid_q;
  assign bit_start_o    = bit_start_q;
  assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_pn_chip_spreader.sv
// Self-checking bench for pn_chip_spreader. The PN generator is modelled as a 127-entry
// m-sequence table (x^7 + x + 1, starting 1,0,0,0,0,0,1). Expected outputs come from a
// slot-level model: which bit (if any) occupies each CHIPS_PER_BIT-chip slot.
module tb_pn_chip_spreader;

  localparam int C = 127;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pn_chip;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready, chip_out, chip_valid, bit_start;
  logic [7:0] underrun_cnt;

  // Second instance with 2-chip slots for the saturation scenario.
  logic       s_reset_n = 1'b0;
  logic       s_in_valid = 1'b0;
  logic       s_in_bit = 1'b0;
  logic       s_in_ready, s_chip_out, s_chip_valid, s_bit_start;
  logic [7:0] s_underrun;

  always #5 clk = ~clk;

  bit pn_tab [0:126];
  int pn_idx = 0;
  always @(posedge clk) begin
    if (!reset_n) pn_idx <= 0;
    else          pn_idx <= (pn_idx == 126) ? 0 : pn_idx + 1;
  end
  assign pn_chip = pn_tab[pn_idx];

  pn_chip_spreader #(.CHIPS_PER_BIT(C), .UNDERRUN_W(8), .PREAMBLE_BITS(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pn_chip_i      (pn_chip),
    .in_valid_i     (in_valid),
    .in_bit_i       (in_bit),
    .in_ready_o     (in_ready),
    .chip_out_o     (chip_out),
    .chip_valid_o   (chip_valid),
    .bit_start_o    (bit_start),
    .underrun_cnt_o (underrun_cnt)
  );

  pn_chip_spreader #(.CHIPS_PER_BIT(2), .UNDERRUN_W(8), .PREAMBLE_BITS(4)) dut_sat (
    .clk            (clk),
    .reset_n        (s_reset_n),
    .pn_chip_i      (pn_chip),
    .in_valid_i     (s_in_valid),
    .in_bit_i       (s_in_bit),
    .in_ready_o     (s_in_ready),
    .chip_out_o     (s_chip_out),
    .chip_valid_o   (s_chip_valid),
    .bit_start_o    (s_bit_start),
    .underrun_cnt_o (s_underrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Slot-level reference model. Cycle t counts from the first cycle after reset.
  int  t;
  bit  mh_vld, mh_bit;
  bit  slot_act [0:255];
  bit  slot_val [0:255];
  int  mund;
  // Observations of the DUT for scenario-level checks.
  int         obs_nvalid, obs_nbs, obs_first_bs, obs_last_bs, obs_last_valid, obs_k;
  logic [6:0] obs_first7;

  task automatic model_reset();
    t = 0; mh_vld = 0; mh_bit = 0; mund = 0;
    for (int i = 0; i < 256; i++) begin slot_act[i] = 0; slot_val[i] = 0; end
    obs_nvalid = 0; obs_nbs = 0; obs_first_bs = -1; obs_last_bs = -1;
    obs_last_valid = -1; obs_k = 0; obs_first7 = 7'd0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // One chip cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit v, input bit b, output bit took);
    bit e_valid, e_out, e_bs, e_rdy;
    int p, s;
    in_valid = v;
    in_bit   = b;
    @(negedge clk);
    e_rdy = !mh_vld;
    if (t == 0) begin
      e_valid = 0; e_out = 0; e_bs = 0;
    end else begin
      p = t - 1;
      s = p / C;
      e_valid = slot_act[s];
      e_out   = e_valid & (slot_val[s] ^ pn_tab[p % 127]);
      e_bs    = e_valid && (p % C == 0);
    end
    vectors++;
    if (chip_valid !== e_valid) begin
      miscompares++; $display("FAIL chip_valid t=%0d got %b exp %b", t, chip_valid, e_valid);
    end
    if (chip_out !== e_out) begin
      miscompares++; $display("FAIL chip_out t=%0d got %b exp %b", t, chip_out, e_out);
    end
    if (bit_start !== e_bs) begin
      miscompares++; $display("FAIL bit_start t=%0d got %b exp %b", t, bit_start, e_bs);
    end
    if (in_ready !== e_rdy) begin
      miscompares++; $display("FAIL in_ready t=%0d got %b exp %b", t, in_ready, e_rdy);
    end
    if (underrun_cnt !== 8'(mund)) begin
      miscompares++; $display("FAIL underrun_cnt t=%0d got %0d exp %0d", t, underrun_cnt, mund);
    end
    if (chip_valid === 1'b1) begin
      obs_nvalid++;
      obs_last_valid = t;
      if (obs_k < 7) begin obs_first7 = {obs_first7[5:0], chip_out}; obs_k++; end
    end
    if (bit_start === 1'b1) begin
      obs_nbs++;
      if (obs_first_bs < 0) obs_first_bs = t;
      obs_last_bs = t;
    end
    took = v && e_rdy;
    @(posedge clk);
    #1;
    if (t % C == C - 1) begin
      s = t / C + 1;
      if (mh_vld) begin
        slot_act[s] = 1; slot_val[s] = mh_bit; mh_vld = 0;
      end else begin
        slot_act[s] = 0;
        if (slot_act[s-1] && mund < 255) mund++;
      end
    end
    if (took) begin mh_vld = 1; mh_bit = b; end
    t++;
  endtask

  task automatic idle(input int n);
    bit took;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, took);
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (chip_valid !== 1'b0) begin miscompares++; $display("FAIL rst_chip_valid got %b exp 0", chip_valid); end
    vectors++;
    if (bit_start !== 1'b0) begin miscompares++; $display("FAIL rst_bit_start got %b exp 0", bit_start); end
    vectors++;
    if (chip_out !== 1'b0) begin miscompares++; $display("FAIL rst_chip_out got %b exp 0", chip_out); end
    vectors++;
    if (underrun_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_underrun got %0d exp 0", underrun_cnt); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    reset_n = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
  endtask

`ifndef PN_PREAMBLE_EN
  task automatic test_single_bit();
    bit took;
    apply_reset();
    step(1'b1, 1'b0, took);
    vectors++;
    if (took !== 1'b1) begin miscompares++; $display("FAIL single_accept got %b exp 1", took); end
    idle(3 * C + 5);
    vectors++;
    if (obs_first_bs !== 128) begin miscompares++; $display("FAIL single_first_bs got %0d exp 128", obs_first_bs); end
    vectors++;
    if (obs_nvalid !== 127) begin miscompares++; $display("FAIL single_nvalid got %0d exp 127", obs_nvalid); end
    vectors++;
    if (obs_first7 !== 7'b1000001) begin
      miscompares++; $display("FAIL single_first7 got %b exp 1000001", obs_first7);
    end
  endtask

  task automatic test_back_to_back();
    bit bits [3];
    int idx, guard;
    bit took;
    bits[0] = 1; bits[1] = 0; bits[2] = 1;
    apply_reset();
    idx = 0; guard = 0;
    while (idx < 3 && guard < 5 * C) begin
      step(1'b1, bits[idx], took);
      if (took) idx++;
      guard++;
    end
    vectors++;
    if (idx !== 3) begin miscompares++; $display("FAIL b2b_accepted got %0d exp 3", idx); end
    idle(4 * C);
    vectors++;
    if (obs_nbs !== 3) begin miscompares++; $display("FAIL b2b_nbs got %0d exp 3", obs_nbs); end
    vectors++;
    if (obs_last_bs - obs_first_bs !== 2 * C) begin
      miscompares++; $display("FAIL b2b_span got %0d exp %0d", obs_last_bs - obs_first_bs, 2 * C);
    end
    vectors++;
    if (obs_nvalid !== 3 * C) begin miscompares++; $display("FAIL b2b_nvalid got %0d exp %0d", obs_nvalid, 3 * C); end
  endtask

  task automatic test_single_underrun();
    bit took;
    apply_reset();
    step(1'b1, 1'b1, took);
    idle(6 * C);
    vectors++;
    if (obs_last_valid - obs_first_bs !== C - 1) begin
      miscompares++;
      $display("FAIL underrun_len got %0d exp %0d", obs_last_valid - obs_first_bs, C - 1);
    end
    vectors++;
    if (underrun_cnt !== 8'd1) begin miscompares++; $display("FAIL underrun_one got %0d exp 1", underrun_cnt); end
  endtask

  task automatic test_random();
    bit took;
    apply_reset();
    for (int i = 0; i < 25 * C; i++) begin
      step(($urandom % 64) == 0, 1'($urandom), took);
    end
  endtask

  task automatic test_reset_mid_bit();
    bit took;
    apply_reset();
    while (t < 2 * C + 60) step(1'b1, 1'($urandom), took);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (chip_valid !== 1'b0 || chip_out !== 1'b0 || bit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs got v%b o%b s%b exp 000", chip_valid, chip_out, bit_start);
    end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 1'b1, took);
    idle(2 * C + 3);
    vectors++;
    if (obs_first_bs !== 128) begin miscompares++; $display("FAIL midrst_first_bs got %0d exp 128", obs_first_bs); end
  endtask

  task automatic test_saturation();
    int exp;
    s_in_valid = 1'b0;
    s_reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_reset_n = 1'b1;
    // 2-chip slots: a bit offered at cycle 4m fills slot 2m+1; slot 2m+2 stays empty.
    for (int m = 0; m < 310; m++) begin
      s_in_valid = 1'b1;
      s_in_bit   = 1'($urandom);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp = (m + 1 > 255) ? 255 : m + 1;
      vectors++;
      if (s_underrun !== 8'(exp)) begin
        miscompares++; $display("FAIL sat_underrun m=%0d got %0d exp %0d", m, s_underrun, exp);
      end
    end
  endtask
`else
  // Preamble build: a bit offered at cycle 0 gives four '1' slots then the data slot.
  // With abort_at >= 0 the run is cut by a reset in cycle abort_at.
  task automatic pre_run(input bit dbit, input int ncyc, input int abort_at);
    bit e_valid, e_out, e_bs, e_rdy, act;
    int p, s, e_und;
    for (int i = 0; i < ncyc; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (chip_valid !== 1'b0 || chip_out !== 1'b0 || bit_start !== 1'b0) begin
          miscompares++;
          $display("FAIL pre_midrst got v%b o%b s%b exp 000", chip_valid, chip_out, bit_start);
        end
        reset_n = 1'b1;
        model_reset();
        return;
      end
      in_valid = (i == 0);
      in_bit   = dbit;
      @(negedge clk);
      e_rdy = (i == 0) || (i >= 5 * C);
      e_und = (i >= 6 * C) ? 1 : 0;
      if (i == 0) begin
        e_valid = 0; e_out = 0; e_bs = 0;
      end else begin
        p = i - 1;
        s = p / C;
        act = (s >= 1 && s <= 5);
        e_valid = act;
        e_out   = act & (((s <= 4) ? 1'b1 : dbit) ^ pn_tab[p % 127]);
        e_bs    = act && (p % C == 0);
      end
      vectors++;
      if (chip_valid !== e_valid || chip_out !== e_out || bit_start !== e_bs) begin
        miscompares++;
        $display("FAIL pre_out t=%0d got v%b o%b s%b exp v%b o%b s%b", i, chip_valid, chip_out,
                 bit_start, e_valid, e_out, e_bs);
      end
      if (in_ready !== e_rdy) begin
        miscompares++; $display("FAIL pre_in_ready t=%0d got %b exp %b", i, in_ready, e_rdy);
      end
      if (underrun_cnt !== 8'(e_und)) begin
        miscompares++; $display("FAIL pre_underrun t=%0d got %0d exp %0d", i, underrun_cnt, e_und);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_preamble();
    apply_reset();
    pre_run(1'b0, 7 * C, -1);
    apply_reset();
    pre_run(1'b1, 7 * C, 2 * C + 60);
    pre_run(1'b0, 7 * C, -1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 7; i++) pn_tab[i] = (i == 0 || i == 6);
    for (int n = 7; n < 127; n++) pn_tab[n] = pn_tab[n-7] ^ pn_tab[n-6];
    model_reset();
    test_reset();
`ifdef PN_PREAMBLE_EN
    test_preamble();
`else
    test_single_bit();
    test_back_to_back();
    test_single_underrun();
    test_random();
    test_reset_mid_bit();
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
